psr_unit: RTL and testbench

Processor status register for the LC-3 datapath.
- Generates and holds the N/Z/P condition codes that the branch-enable logic consumes.
- Holds the privilege bit and the 3-bit priority level.
- Handles the full-PSR load used by RTI, supervisor entry on TRAP/interrupt, and a registered interrupt-pending compare for the control FSM.
- Sits between the shared 16-bit bus and the control unit; its nzp output drives branch evaluation.

---
 rtl/lc3_pkg.sv | 18 +
 rtl/psr_unit_nzp_gen.sv | 13 +
 rtl/psr_unit.sv | 74 +++++++
 tb/tb_psr_unit.sv | 103 ++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// lc3_pkg: shared PSR bit positions, reset value, cc_t type and one-hot helper
package lc3_pkg;
  localparam int PSR_PRIV = 15;
  localparam int PSR_PRI_HI = 10;
  localparam int PSR_PRI_LO = 8;
  localparam int PSR_N = 2;
  localparam int PSR_Z = 1;
  localparam int PSR_P = 0;
  localparam logic [15:0] PSR_RESET = 16'h0002;
  typedef struct packed {
    logic n;
    logic z;
    logic p;
  } cc_t;
  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
  endfunction
endpackage

// File: rtl/psr_unit_nzp_gen.sv
// nzp_gen: bus_i -> one-hot {n,z,p} condition codes (bus_i in 16, cc_o out cc_t)
module nzp_gen
  import lc3_pkg::*;
(
  input  logic [15:0] bus_i,
  output cc_t         cc_o
);
  always_comb begin
    cc_o.n = bus_i[15];
    cc_o.z = bus_i == 16'h0000;
    cc_o.p = !bus_i[15] && bus_i != 16'h0000;
  end
endmodule

// File: rtl/psr_unit.sv
// psr_unit: LC-3 PSR (in: clk reset bus ld_cc ld_psr enter_super int_ack intr_req intr_pri; out: nzp priv pri psr_out int_pending priv_viol psr_err)
module psr_unit
  import lc3_pkg::*;
#(
  parameter logic [15:0] RESET_PSR = PSR_RESET
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bus,
  input  logic        ld_cc,
  input  logic        ld_psr,
  input  logic        enter_super,
  input  logic        int_ack,
  input  logic        intr_req,
  input  logic [2:0]  intr_pri,
  output logic [2:0]  nzp,
  output logic        priv,
  output logic [2:0]  pri,
  output logic [15:0] psr_out,
  output logic        int_pending,
  output logic        priv_viol,
  output logic        psr_err
);
  cc_t bus_cc;
  cc_t nzp_q, nzp_d;
  logic priv_q, priv_d, pend_q, pend_d, viol_q, viol_d, err_q, err_d;
  logic [2:0] pri_q, pri_d;
  logic cc_ok;
  nzp_gen u_nzp_gen (.bus_i(bus), .cc_o(bus_cc));
  assign cc_ok = is_onehot3(bus[PSR_N:PSR_P]);
  always_comb begin
    priv_d = priv_q;
    pri_d  = pri_q;
    nzp_d  = nzp_q;
    viol_d = 1'b0;
    err_d  = 1'b0;
    pend_d = intr_req && (intr_pri > pri_q);
    if (ld_psr) begin
      viol_d = priv_q;
      err_d  = !priv_q && !cc_ok;
      priv_d = priv_q ? priv_q : bus[PSR_PRIV];
      pri_d  = priv_q ? pri_q : bus[PSR_PRI_HI:PSR_PRI_LO];
      nzp_d  = priv_q ? nzp_q : cc_ok ? cc_t'(bus[PSR_N:PSR_P]) : cc_t'(3'b010);
    end else begin
      priv_d = enter_super ? 1'b0 : priv_q;
      pri_d  = (enter_super && int_ack) ? intr_pri : pri_q;
      nzp_d  = ld_cc ? bus_cc : nzp_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      priv_q <= RESET_PSR[PSR_PRIV];
      pri_q  <= RESET_PSR[PSR_PRI_HI:PSR_PRI_LO];
      nzp_q  <= cc_t'(RESET_PSR[PSR_N:PSR_P]);
      pend_q <= 1'b0;
      viol_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      priv_q <= priv_d;
      pri_q  <= pri_d;
      nzp_q  <= nzp_d;
      pend_q <= pend_d;
      viol_q <= viol_d;
      err_q  <= err_d;
    end
  end
  assign nzp         = nzp_q;
  assign priv        = priv_q;
  assign pri         = pri_q;
  assign psr_out     = {priv_q, 4'b0, pri_q, 5'b0, nzp_q};
  assign int_pending = pend_q;
  assign priv_viol   = viol_q;
  assign psr_err     = err_q;
endmodule

// File: tb/tb_psr_unit.sv
// tb_psr_unit: directed self-checking bench for psr_unit
module tb_psr_unit;
  logic clk = 1'b0;
  logic reset, ld_cc, ld_psr, enter_super, int_ack, intr_req;
  logic [15:0] bus;
  logic [2:0] intr_pri;
  logic [2:0] nzp, pri;
  logic priv, int_pending, priv_viol, psr_err;
  logic [15:0] psr_out;
  int vectors = 0;
  int miscompares = 0;
  psr_unit dut (
    .clk(clk), .reset(reset), .bus(bus), .ld_cc(ld_cc), .ld_psr(ld_psr),
    .enter_super(enter_super), .int_ack(int_ack), .intr_req(intr_req),
    .intr_pri(intr_pri), .nzp(nzp), .priv(priv), .pri(pri), .psr_out(psr_out),
    .int_pending(int_pending), .priv_viol(priv_viol), .psr_err(psr_err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    ld_cc = 0; ld_psr = 0; enter_super = 0; int_ack = 0; reset = 0;
  endtask
  initial begin
    idle(); bus = 0; intr_req = 0; intr_pri = 0;
    reset = 1; tick(); reset = 0;
    chk("rst_psr", psr_out, 16'h0002);
    chk("rst_pend", {15'b0, int_pending}, 16'h0);
    chk("rst_viol", {15'b0, priv_viol}, 16'h0);
    chk("rst_err", {15'b0, psr_err}, 16'h0);
    ld_cc = 1; bus = 16'h8000; tick();
    chk("cc_neg", {13'b0, nzp}, 16'h4);
    bus = 16'h0000; tick();
    chk("cc_zero", {13'b0, nzp}, 16'h2);
    bus = 16'h0001; tick();
    chk("cc_pos", {13'b0, nzp}, 16'h1);
    idle(); bus = 16'h8000; tick();
    chk("idle_hold", psr_out, 16'h0001);
    ld_psr = 1; bus = 16'h8401; tick();
    chk("rti_priv", {15'b0, priv}, 16'h1);
    chk("rti_pri", {13'b0, pri}, 16'h4);
    chk("rti_nzp", {13'b0, nzp}, 16'h1);
    chk("rti_psr", psr_out, 16'h8401);
    chk("rti_noviol", {15'b0, priv_viol}, 16'h0);
    bus = 16'h0002; tick();
    chk("user_psr", psr_out, 16'h8401);
    chk("user_viol", {15'b0, priv_viol}, 16'h1);
    idle(); tick();
    chk("viol_clear", {15'b0, priv_viol}, 16'h0);
    chk("viol_hold", psr_out, 16'h8401);
    enter_super = 1; int_ack = 0; tick(); idle();
    chk("super_psr", psr_out, 16'h0401);
    ld_psr = 1; ld_cc = 1; bus = 16'h0307; tick(); idle();
    chk("bad_pri", {13'b0, pri}, 16'h3);
    chk("bad_nzp", {13'b0, nzp}, 16'h2);
    chk("bad_err", {15'b0, psr_err}, 16'h1);
    chk("bad_psr", psr_out, 16'h0302);
    tick();
    chk("err_clear", {15'b0, psr_err}, 16'h0);
    intr_req = 1; intr_pri = 3'd5; tick();
    chk("pend_5gt3", {15'b0, int_pending}, 16'h1);
    enter_super = 1; int_ack = 1; tick(); idle();
    chk("ack_priv", {15'b0, priv}, 16'h0);
    chk("ack_pri", {13'b0, pri}, 16'h5);
    chk("ack_pend_old", {15'b0, int_pending}, 16'h1);
    tick();
    chk("ack_pend_drop", {15'b0, int_pending}, 16'h0);
    intr_pri = 3'd3; ld_psr = 1; bus = 16'h0301; tick(); idle();
    chk("pri3", {13'b0, pri}, 16'h3);
    tick();
    chk("eq_nopend", {15'b0, int_pending}, 16'h0);
    tick();
    chk("eq_nopend2", {15'b0, int_pending}, 16'h0);
    intr_pri = 3'd4; tick();
    chk("pend_4gt3", {15'b0, int_pending}, 16'h1);
    intr_req = 0; int_ack = 1; intr_pri = 3'd6; tick(); idle();
    chk("ack_alone", {13'b0, pri}, 16'h3);
    chk("req_off", {15'b0, int_pending}, 16'h0);
    ld_psr = 1; bus = 16'h8304; tick(); idle();
    chk("user_again", psr_out, 16'h8304);
    enter_super = 1; ld_cc = 1; bus = 16'hFFFF; tick(); idle();
    chk("sim_priv", {15'b0, priv}, 16'h0);
    chk("sim_nzp", {13'b0, nzp}, 16'h4);
    chk("sim_psr", psr_out, 16'h0304);
    intr_req = 1; intr_pri = 3'd7; tick();
    chk("pend_7", {15'b0, int_pending}, 16'h1);
    reset = 1; ld_psr = 1; bus = 16'h8401; tick(); idle();
    chk("rst_dom_psr", psr_out, 16'h0002);
    chk("rst_dom_pend", {15'b0, int_pending}, 16'h0);
    chk("rst_dom_err", {15'b0, psr_err}, 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
